// File: rtl/contador_parkimetro_multi.sv
// contador_parkimetro_multi: per-spot sensor sync/debounce/FSM, occupancy count and 4-digit 7-seg display
module contador_parkimetro_multi #(
    parameter int SPOTS        = 4,
    parameter int DEB_CYCLES   = 16,
    parameter int REFRESH_BITS = 18
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [SPOTS-1:0] a,
    input  logic [SPOTS-1:0] b,
    output logic [SPOTS-1:0] entra,
    output logic [SPOTS-1:0] sale,
    output logic [SPOTS-1:0] error,
    output logic [6:0]       ocupados,
    output logic [6:0]       libres,
    output logic             lleno,
    output logic [3:0]       an,
    output logic [7:0]       sseg
);
    localparam int CW = $clog2(DEB_CYCLES + 1);
    typedef enum logic [2:0] {IDLE, ARRIVING, PARKED, LEAVING, ERR} st_t;
    logic [SPOTS-1:0] occ;
    for (genvar i = 0; i < SPOTS; i++) begin : g_spot
        logic [1:0] s1_q, s2_q, f_q;
        logic [CW-1:0] cnt_q;
        st_t st_q, st_d;
        logic occ_q, occ_d, en_q, en_d, sa_q, sa_d;
        // filter only follows the synchronised pair after DEB_CYCLES unbroken cycles of disagreement
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                s1_q  <= 2'b00;
                s2_q  <= 2'b00;
                f_q   <= 2'b00;
                cnt_q <= '0;
            end else begin
                s1_q <= {a[i], b[i]};
                s2_q <= s1_q;
                if (s2_q == f_q) cnt_q <= '0;
                else if (cnt_q == CW'(DEB_CYCLES - 1)) begin
                    f_q   <= s2_q;
                    cnt_q <= '0;
                end else cnt_q <= cnt_q + 1'b1;
            end
        end
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                st_q  <= IDLE;
                occ_q <= 1'b0;
                en_q  <= 1'b0;
                sa_q  <= 1'b0;
            end else begin
                st_q  <= st_d;
                occ_q <= occ_d;
                en_q  <= en_d;
                sa_q  <= sa_d;
            end
        end
        always_comb begin
            st_d  = st_q;
            occ_d = occ_q;
            en_d  = 1'b0;
            sa_d  = 1'b0;
            case (st_q)
                IDLE:     st_d = f_q == 2'b10 ? ARRIVING : f_q == 2'b00 ? IDLE : ERR;
                ARRIVING: begin
                    st_d  = f_q == 2'b11 ? PARKED : f_q == 2'b00 ? IDLE : f_q == 2'b01 ? ERR : ARRIVING;
                    en_d  = f_q == 2'b11;
                    occ_d = occ_q | (f_q == 2'b11);
                end
                PARKED:   st_d = f_q == 2'b10 ? LEAVING : f_q == 2'b11 ? PARKED : ERR;
                LEAVING:  begin
                    st_d  = f_q == 2'b11 ? PARKED : f_q == 2'b00 ? IDLE : f_q == 2'b01 ? ERR : LEAVING;
                    sa_d  = f_q == 2'b00;
                    occ_d = occ_q & (f_q != 2'b00);
                end
                ERR:      begin
                    // leaving the error state with an empty sensor frees a spot that was held
                    st_d  = f_q == 2'b00 ? IDLE : (f_q == 2'b11 && occ_q) ? PARKED : ERR;
                    sa_d  = f_q == 2'b00 && occ_q;
                    occ_d = occ_q & (f_q != 2'b00);
                end
                default:  st_d = IDLE;
            endcase
        end
        assign entra[i] = en_q;
        assign sale[i]  = sa_q;
        assign error[i] = st_q == ERR;
        assign occ[i]   = occ_q;
    end
    logic [6:0] pop;
    logic [6:0] ocup_q, libres_q;
    logic lleno_q;
    always_comb begin
        pop = '0;
        for (int k = 0; k < SPOTS; k++) pop = pop + 7'(occ[k]);
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ocup_q   <= '0;
            libres_q <= 7'(SPOTS);
            lleno_q  <= 1'b0;
        end else begin
            ocup_q   <= pop;
            libres_q <= 7'(SPOTS) - pop;
            lleno_q  <= pop == 7'(SPOTS);
        end
    end
    assign ocupados = ocup_q;
    assign libres   = libres_q;
    assign lleno    = lleno_q;
    logic [REFRESH_BITS-1:0] ref_q;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) ref_q <= '0;
        else ref_q <= ref_q + 1'b1;
    end
    function automatic logic [6:0] seg7(input logic [6:0] v);
        case (v)
            7'd0:    seg7 = 7'b1000000;
            7'd1:    seg7 = 7'b1111001;
            7'd2:    seg7 = 7'b0100100;
            7'd3:    seg7 = 7'b0110000;
            7'd4:    seg7 = 7'b0011001;
            7'd5:    seg7 = 7'b0010010;
            7'd6:    seg7 = 7'b0000010;
            7'd7:    seg7 = 7'b1111000;
            7'd8:    seg7 = 7'b0000000;
            7'd9:    seg7 = 7'b0010000;
            default: seg7 = 7'b1111111;
        endcase
    endfunction
    logic [1:0] sel;
    logic [6:0] val, dig;
    always_comb begin
        sel  = ref_q[REFRESH_BITS-1 -: 2];
        val  = sel[1] ? ocup_q : libres_q;
        dig  = sel[0] ? val / 7'd10 : val % 7'd10;
        an   = ~(4'b0001 << sel);
        sseg = {~(sel == 2'd0 && |error), seg7(dig)};
    end
endmodule

// File: tb/tb_contador_parkimetro_multi.sv
// tb_contador_parkimetro_multi: directed stimulus with a pulse scoreboard for the parking meter
module tb_contador_parkimetro_multi;
    logic clk = 1'b0, rst = 1'b1;
    logic [3:0] a = '0, b = '0;
    logic [3:0] entra, sale, error, an;
    logic [6:0] ocupados, libres;
    logic lleno;
    logic [7:0] sseg;
    int checks = 0, failures = 0, cyc = 0;

    contador_parkimetro_multi #(.SPOTS(4), .DEB_CYCLES(4), .REFRESH_BITS(6)) dut (
        .clk(clk), .reset(rst), .a(a), .b(b), .entra(entra), .sale(sale), .error(error),
        .ocupados(ocupados), .libres(libres), .lleno(lleno), .an(an), .sseg(sseg)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {logic [31:0] c; logic [3:0] e; logic [3:0] s;} ev_t;
    ev_t exp_q[$], obs_q[$];

    always @(negedge clk) if (!rst && (entra != 0 || sale != 0)) obs_q.push_back({32'(cyc), entra, sale});

    task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
        checks++;
        assert (o === e) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic setab(input int i, input logic [1:0] v);
        a[i] = v[1];
        b[i] = v[0];
    endtask

    task automatic expect_ev(input logic [3:0] e, input logic [3:0] s, input int lat);
        exp_q.push_back({32'(cyc + lat), e, s});
    endtask

    task automatic check_events();
        ev_t o, e;
        chk("pulses_idle", 64'(entra | sale), 64'(0));
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.size() > 0 ? obs_q.pop_front() : '0;
            chk("event", 64'(o), 64'(e));
        end
        while (obs_q.size() > 0) begin
            o = obs_q.pop_front();
            chk("extra_event", 64'(o), 64'(0));
        end
    endtask

    task automatic check_counts(input logic [6:0] occ);
        chk("ocupados", 64'(ocupados), 64'(occ));
        chk("libres", 64'(libres), 64'(7'd4 - occ));
        chk("lleno", 64'(lleno), 64'(occ == 7'd4));
    endtask

    task automatic wait_digit(input int k);
        int n = 0;
        logic [3:0] want;
        want = ~(4'b0001 << k);
        while (an !== want && n < 80) begin
            step(1);
            n++;
        end
        chk("an_select", 64'(an), 64'(want));
    endtask

    initial begin
        step(3);
        rst = 1'b0;
        step(5);
        // 1: reset asserted mid-sequence clears everything asynchronously
        setab(0, 2'b10);
        step(4);
        rst = 1'b1;
        #2;
        chk("rst_an", 64'(an), 64'(4'b1110));
        check_counts(7'd0);
        chk("rst_error", 64'(error), 64'(0));
        chk("rst_pulses", 64'(entra | sale), 64'(0));
        setab(0, 2'b00);
        step(3);
        rst = 1'b0;
        step(20);
        check_counts(7'd0);
        chk("idle_error", 64'(error), 64'(0));
        check_events();
        // 2: park and leave on spot 0, with a re-park in the middle
        setab(0, 2'b10);
        step(20);
        setab(0, 2'b11);
        expect_ev(4'b0001, 4'b0000, 7);
        step(20);
        check_events();
        check_counts(7'd1);
        setab(0, 2'b10);
        step(20);
        setab(0, 2'b11);
        step(20);
        setab(0, 2'b10);
        step(20);
        setab(0, 2'b00);
        expect_ev(4'b0000, 4'b0001, 7);
        step(20);
        check_events();
        check_counts(7'd0);
        // 3: aborted arrival, then invalid jump to 11 on spot 1
        setab(1, 2'b10);
        step(20);
        setab(1, 2'b00);
        step(20);
        setab(1, 2'b11);
        step(20);
        chk("err1", 64'(error), 64'(4'b0010));
        wait_digit(0);
        chk("dp_err_digit0", 64'(sseg), 64'(8'h19));
        setab(1, 2'b00);
        step(20);
        chk("err1_clear", 64'(error), 64'(0));
        check_events();
        check_counts(7'd0);
        // 4: three-cycle glitch on spot 2 never reaches the filter
        setab(2, 2'b10);
        step(3);
        setab(2, 2'b00);
        step(20);
        chk("glitch_error", 64'(error), 64'(0));
        check_events();
        // 5: all spots park together, then spot 3 drops straight to 00
        for (int i = 0; i < 4; i++) setab(i, 2'b10);
        step(20);
        for (int i = 0; i < 4; i++) setab(i, 2'b11);
        expect_ev(4'b1111, 4'b0000, 7);
        step(20);
        check_events();
        check_counts(7'd4);
        wait_digit(3);
        chk("full_d3", 64'(sseg), 64'(8'hC0));
        wait_digit(2);
        chk("full_d2", 64'(sseg), 64'(8'h99));
        wait_digit(1);
        chk("full_d1", 64'(sseg), 64'(8'hC0));
        wait_digit(0);
        chk("full_d0", 64'(sseg), 64'(8'hC0));
        setab(3, 2'b00);
        expect_ev(4'b0000, 4'b1000, 8);
        step(7);
        chk("err3", 64'(error), 64'(4'b1000));
        step(1);
        chk("err3_clear", 64'(error), 64'(0));
        step(20);
        check_events();
        check_counts(7'd3);
        // 6: digit rotation every 16 cycles showing 03 / 01
        wait_digit(0);
        chk("d0", 64'(sseg), 64'(8'hF9));
        step(16);
        chk("an1", 64'(an), 64'(4'b1101));
        chk("d1", 64'(sseg), 64'(8'hC0));
        step(16);
        chk("an2", 64'(an), 64'(4'b1011));
        chk("d2", 64'(sseg), 64'(8'hB0));
        step(16);
        chk("an3", 64'(an), 64'(4'b0111));
        chk("d3", 64'(sseg), 64'(8'hC0));
        check_events();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
